log_dump_ctrl: RTL
==================

Name: log_dump_ctrl

Overview:
- Downstream readout stage for the I/Q sample logger.
- Once the logger reports memory full, this block commands it into read mode and walks every address from 0 to 2^ADDR_WIDTH-1.
- For each word it captures the 16-bit I/Q sample and streams it as bytes over a valid/ready byte interface toward the UART/host link.
- Provides busy/done status to the host control register block.

Parameters:
- ADDR_WIDTH, 15, logger memory address width; one word per address.
- DATA_WIDTH, 16, meaningful bits per logged word; must be a multiple of 8; bytes per word NB = DATA_WIDTH/8.
- RD_LATENCY, 2, cycles from o_addr change to valid i_mem_data; legal range 1..7.

Ports:
- clk  in  1  system clock, rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_start  in  1  one-cycle dump request from host.
- i_mem_full  in  1  logger memory-full flag.
- i_mem_data  in  32  logger read data; bits [DATA_WIDTH-1:0] used, I in [15:8], Q in [7:0].
- o_read_log  out  1  one-cycle pulse moving the logger FULL->READ.
- o_addr  out  ADDR_WIDTH  logger read address.
- o_tx_data  out  8  byte to link.
- o_tx_valid  out  1  o_tx_data valid.
- i_tx_ready  in  1  link accepts byte when valid&ready at a rising edge.
- o_busy  out  1  high from accepted start until DONE.
- o_done  out  1  one-cycle pulse after last byte accepted.

Behaviour:
- Reset (i_rst_n=0 at clk edge): state IDLE; o_read_log=0, o_addr=0, o_tx_data=0, o_tx_valid=0, o_busy=0, o_done=0. Takes effect mid-dump: no further bytes, no o_done.
- States: IDLE, WAIT_FULL, ARM, FETCH, SEND, DONE.
- IDLE: on i_start -> WAIT_FULL; o_busy=1 next cycle. i_start is ignored in every other state.
- WAIT_FULL: stay until i_mem_full=1, then -> ARM.
- ARM: o_read_log=1 for exactly this cycle; o_addr=0; -> FETCH.
- FETCH: hold o_addr; latency counter counts RD_LATENCY cycles. On the last count, register i_mem_data[DATA_WIDTH-1:0] into the shift register, set byte index=0, -> SEND.
- SEND:
  - o_tx_valid=1; o_tx_data = current byte, MSB first (I byte, then Q byte).
  - o_tx_data stays stable while valid & !ready.
  - On each handshake, advance the byte index.
  - After byte NB-1 is accepted: if o_addr is all-ones -> DONE; else o_addr+1 -> FETCH.
  - o_tx_valid drops the cycle after the final handshake of a word; there is no back-to-back streaming across words.
- DONE: o_done=1 for one cycle, o_busy=0, o_addr=0 -> IDLE.
- Address counter has no wrap: the terminal address ends the dump.
- Total payload is exactly NB*2^ADDR_WIDTH bytes, 65536 at defaults.
- If i_mem_full drops during FETCH/SEND (logger re-run), the block does not react; that is the host's responsibility.
- Per-word cycle cost with ready tied high: RD_LATENCY + NB + 1.

Optional Feature:
- Macro LOG_DUMP_HEADER_EN.
- Defined: after ARM, a HEADER state sends 0xA5, 0x5A, then ADDR_WIDTH zero-extended to 8 bits, each with the same valid/ready rules, before the first FETCH. Payload is NB*2^ADDR_WIDTH + 3 bytes.
- Undefined: HEADER state, header constants and its logic are absent; ARM goes directly to FETCH.

Decomposition:
- Package log_dump_pkg:
  - state encoding localparams;
  - HDR_SYNC0=8'hA5, HDR_SYNC1=8'h5A;
  - function computing NB.
- Natural sub-module: byte_serializer. It takes a parallel DATA_WIDTH word with load strobe, runs the valid/ready byte handshake, and signals last-byte-accepted.
- The FSM, address counter and latency counter stay in log_dump_ctrl.

Test Plan:
- Reset mid-dump: after 5 bytes, drive i_rst_n=0 one cycle -> next cycle all outputs 0, state IDLE, no o_done ever; a new i_start restarts at address 0.
- Full dump, ADDR_WIDTH=4, RD_LATENCY=2, ready=1, model memory data=16'h{addr,~addr} per address:
  - expect o_read_log one pulse;
  - 32 bytes 00,FF,01,FE,...,0F,F0 in order;
  - o_done one pulse;
  - total cycles = 16*(2+2+1)+overhead within ±4.
- Start before full: i_start with i_mem_full=0 for 20 cycles -> o_busy=1, no o_read_log, no valid. Raise full -> o_read_log pulse 1 cycle later, then dump proceeds.
- Backpressure: random i_tx_ready 30% duty -> o_tx_data never changes while valid&!ready; byte sequence identical to the ready=1 run.
- Start ignored: pulse i_start again mid-dump -> no restart, byte count unchanged (32), single o_done.
- Header (LOG_DUMP_HEADER_EN defined, ADDR_WIDTH=4) -> first bytes A5,5A,04, then 32 payload bytes; undefined -> first byte 00.

Source files
------------

// File: rtl/log_dump_pkg.sv
// log_dump_pkg: shared types and constants for the I/Q logger readout path.
//   state_t          - readout FSM state encoding
//   HDR_SYNC0/1      - stream header sync bytes (only with LOG_DUMP_HEADER_EN)
//   bytes_per_word() - number of link bytes per logged word
// Build option: LOG_DUMP_HEADER_EN adds the HEADER state and its constants.
package log_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_FULL = 3'd1,
    ST_ARM       = 3'd2,
    ST_FETCH     = 3'd3,
    ST_SEND      = 3'd4,
    ST_DONE      = 3'd5
`ifdef LOG_DUMP_HEADER_EN
    ,ST_HEADER   = 3'd6
`endif
  } state_t;

`ifdef LOG_DUMP_HEADER_EN
  localparam logic [7:0] HDR_SYNC0 = 8'hA5;
  localparam logic [7:0] HDR_SYNC1 = 8'h5A;
`endif

  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/byte_serializer.sv
// byte_serializer: splits a parallel word into bytes, MSB first, over a
// valid/ready handshake.
//   clk, rst_n  - clock, synchronous active-low reset
//   load        - strobe: capture data and start sending (wins over handshake)
//   single      - with load: send only the top byte of data
//   data        - parallel word
//   ready       - sink accepts tx_data when tx_valid & ready at a rising edge
//   tx_data     - current byte, held stable while tx_valid & !ready
//   tx_valid    - byte available
//   last        - combinational: final byte of this load is being accepted
module byte_serializer
  import log_dump_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  single,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  output logic                  last
);

  localparam int NB = bytes_per_word(DATA_WIDTH);
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  logic [DATA_WIDTH-1:0] shreg;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_last;

  assign tx_data = shreg[DATA_WIDTH-1 -: 8];
  assign last    = tx_valid && ready && (idx == idx_last);

  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg    <= '0;
      idx      <= '0;
      idx_last <= '0;
      tx_valid <= 1'b0;
    end else if (load) begin
      shreg    <= data;
      idx      <= '0;
      idx_last <= single ? '0 : IW'(NB - 1);
      tx_valid <= 1'b1;
    end else if (tx_valid && ready) begin
      if (idx == idx_last) begin
        // Keep the last byte on tx_data; only valid drops.
        tx_valid <= 1'b0;
      end else begin
        shreg <= shreg << 8;
        idx   <= idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/log_dump_ctrl.sv
// log_dump_ctrl: reads the full I/Q logger memory and streams it as bytes.
// After a host start and logger-full, pulses o_read_log, then for every
// address 0..2^ADDR_WIDTH-1 waits the read latency, captures the word and
// sends it MSB first over a valid/ready byte link.
//   clk, i_rst_n        - clock, synchronous active-low reset
//   i_start             - one-cycle dump request (honoured only when idle)
//   i_mem_full          - logger memory full
//   i_mem_data          - logger read data, [DATA_WIDTH-1:0] used
//   o_read_log          - one-cycle pulse switching the logger to read mode
//   o_addr              - logger read address
//   o_tx_data/o_tx_valid/i_tx_ready - byte link
//   o_busy              - dump in progress
//   o_done              - one-cycle pulse after the last byte is accepted
// Build option: LOG_DUMP_HEADER_EN sends A5, 5A, ADDR_WIDTH before the data.
module log_dump_ctrl
  import log_dump_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 16,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_mem_full,
  input  logic [31:0]           i_mem_data,
  output logic                  o_read_log,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
  localparam logic [2:0]            LAT_LAST  = 3'(RD_LATENCY);

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] addr;
  logic [2:0]            lat_cnt;
  logic                  ser_load;
  logic                  ser_single;
  logic [DATA_WIDTH-1:0] ser_word;
  logic                  ser_last;

`ifdef LOG_DUMP_HEADER_EN
  logic [1:0] hdr_idx;
  logic [7:0] hdr_next_byte;
  // Byte that follows the one currently being sent.
  assign hdr_next_byte = (hdr_idx == 2'd0) ? HDR_SYNC1 : 8'(ADDR_WIDTH);
`endif

  generate
    if (DATA_WIDTH < 32) begin : g_unused
      logic unused_mem_bits;
      assign unused_mem_bits = ^i_mem_data[31:DATA_WIDTH];
    end
  endgenerate

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    ser_load   = 1'b0;
    ser_single = 1'b0;
    ser_word   = i_mem_data[DATA_WIDTH-1:0];
    unique case (state)
      ST_IDLE:      if (i_start) state_next = ST_WAIT_FULL;
      ST_WAIT_FULL: if (i_mem_full) state_next = ST_ARM;
`ifdef LOG_DUMP_HEADER_EN
      ST_ARM: begin
        state_next = ST_HEADER;
        ser_load   = 1'b1;
        ser_single = 1'b1;
        ser_word   = DATA_WIDTH'(HDR_SYNC0) << (DATA_WIDTH - 8);
      end
      ST_HEADER: begin
        if (ser_last) begin
          if (hdr_idx == 2'd2) begin
            state_next = ST_FETCH;
          end else begin
            ser_load   = 1'b1;
            ser_single = 1'b1;
            ser_word   = DATA_WIDTH'(hdr_next_byte) << (DATA_WIDTH - 8);
          end
        end
      end
`else
      ST_ARM:       state_next = ST_FETCH;
`endif
      // The address register changes on entry to FETCH; sampling at count
      // RD_LATENCY gives the memory RD_LATENCY full cycles after that.
      ST_FETCH: begin
        if (lat_cnt == LAT_LAST) begin
          ser_load   = 1'b1;
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (ser_last) state_next = (addr == ADDR_LAST) ? ST_DONE : ST_FETCH;
      end
      ST_DONE:      state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      addr    <= '0;
      lat_cnt <= '0;
    end else begin
      state   <= state_next;
      lat_cnt <= (state == ST_FETCH && state_next == ST_FETCH) ? lat_cnt + 3'd1 : 3'd0;
      if (state == ST_SEND && ser_last) begin
        // The terminal address ends the dump and the counter returns to 0.
        addr <= (addr == ADDR_LAST) ? '0 : addr + 1'b1;
      end else if (state == ST_ARM) begin
        addr <= '0;
      end
    end
  end

`ifdef LOG_DUMP_HEADER_EN
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      hdr_idx <= '0;
    end else if (state == ST_ARM) begin
      hdr_idx <= '0;
    end else if (state == ST_HEADER && ser_last) begin
      hdr_idx <= hdr_idx + 2'd1;
    end
  end
`endif

  byte_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ser (
    .clk      (clk),
    .rst_n    (i_rst_n),
    .load     (ser_load),
    .single   (ser_single),
    .data     (ser_word),
    .ready    (i_tx_ready),
    .tx_data  (o_tx_data),
    .tx_valid (o_tx_valid),
    .last     (ser_last)
  );

  assign o_addr     = addr;
  assign o_read_log = (state == ST_ARM);
  assign o_done     = (state == ST_DONE);
  assign o_busy     = (state != ST_IDLE) && (state != ST_DONE);

endmodule
